// File: rtl/tlc_nway_phase_ctrl.sv
// tlc_nway_phase_ctrl
// N-phase traffic light controller with tick-based durations, demand-driven
// phase selection and actuated green extension.
// Optional feature: define TLC_EMERGENCY_EN to compile in emergency
// preemption. Without it, emg_req/emg_phase are accepted but ignored.
// Lamp group of phase k sits at lights[3k+2:3k], encoded {R,Y,G}.

module tlc_nway_phase_ctrl #(
  parameter int NUM_PHASES   = 4,
  parameter int TIMER_W      = 8,
  parameter int MIN_GREEN    = 5,
  parameter int MAX_GREEN    = 10,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic [NUM_PHASES-1:0]   veh_req,
  input  logic                    emg_req,
  input  logic [PW-1:0]           emg_phase,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [PW-1:0]           cur_phase,
  output logic [1:0]              state
);

  localparam int LW  = 3 * NUM_PHASES;
  localparam int PW1 = PW + 1;

  // A programmed duration of zero behaves as a one-tick state, and the green
  // cap can never be shorter than the guaranteed green.
  localparam int MIN_I = (MIN_GREEN < 1) ? 1 : MIN_GREEN;
  localparam int MAX_I = (MAX_GREEN < MIN_I) ? MIN_I : MAX_GREEN;
  localparam int YEL_I = (YELLOW_TICKS < 1) ? 1 : YELLOW_TICKS;
  localparam int AR_I  = (ALLRED_TICKS < 1) ? 1 : ALLRED_TICKS;

  localparam logic [TIMER_W-1:0] T_ONE  = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] MIN_D  = TIMER_W'(MIN_I);
  localparam logic [TIMER_W-1:0] MAX_M1 = TIMER_W'(MAX_I - 1);
  localparam logic [TIMER_W-1:0] YEL_D  = TIMER_W'(YEL_I);
  localparam logic [TIMER_W-1:0] AR_D   = TIMER_W'(AR_I);
  localparam logic [PW-1:0]      LAST_PHASE = PW'(NUM_PHASES - 1);
  localparam logic [LW-1:0]      ALL_RED = {NUM_PHASES{3'b100}};

  typedef enum logic [1:0] {
    ST_ALLRED = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  state_t                st_q, st_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [TIMER_W-1:0]    gcnt_q, gcnt_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [LW-1:0]         lights_q, lights_d;

  logic [2*NUM_PHASES-1:0] req_dbl;
  logic [NUM_PHASES-1:0]   req_rot;
  logic [NUM_PHASES-1:0]   req_tmp;
  logic [NUM_PHASES-1:0]   own_mask;
  logic                    own_only;
  logic                    found;
  int                      sum;
  logic [PW-1:0]           search_phase;
  logic                    green_done;
  logic                    emg_valid;

  // Lamp image for a given state/phase: every group red except the owner.
  function automatic logic [LW-1:0] lamp_decode(input state_t s, input logic [PW-1:0] p);
    logic [2:0]    grp;
    logic [LW-1:0] mask;
    case (s)
      ST_GREEN:  grp = 3'b001;
      ST_YELLOW: grp = 3'b010;
      default:   grp = 3'b100;
    endcase
    mask = LW'(3'b111) << (int'(p) * 3);
    return (ALL_RED & ~mask) | (LW'(grp) << (int'(p) * 3));
  endfunction

`ifdef TLC_EMERGENCY_EN
  // A preemption request only counts when it names an existing phase.
  assign emg_valid = emg_req && ({1'b0, emg_phase} < PW1'(NUM_PHASES));
`else
  logic unused_emg;
  assign unused_emg = ^{emg_req, emg_phase};
  assign emg_valid  = 1'b0;
`endif

  // Green may only be extended while its own approach is the sole demand.
  assign own_mask   = NUM_PHASES'(1) << phase_q;
  assign own_only   = (veh_req == own_mask);
  assign green_done = (timer_q <= T_ONE) && ((gcnt_q >= MAX_M1) || !own_only);

  // Next phase: first requesting approach after the current one, wrapping
  // round to the current one last; plain rotation when nothing is requested.
  always_comb begin
    req_dbl = {veh_req, veh_req};
    req_rot = NUM_PHASES'(req_dbl >> (int'(phase_q) + 1));
    req_tmp = '0;
    found   = 1'b0;
    sum     = int'(phase_q) + 1;
    for (int j = 0; j < NUM_PHASES; j++) begin
      req_tmp = req_rot >> j;
      if (!found && req_tmp[0]) begin
        found = 1'b1;
        sum   = int'(phase_q) + 1 + j;
      end
    end
    if (sum >= NUM_PHASES) begin
      sum = sum - NUM_PHASES;
    end
    search_phase = PW'(sum);
  end

  // Next-state, timer and lamp image; only emergency preemption and hold act
  // between ticks, everything else waits for tick_en.
  always_comb begin
    st_d    = st_q;
    timer_d = timer_q;
    gcnt_d  = gcnt_q;
    phase_d = phase_q;
    case (st_q)
      ST_ALLRED: begin
        if (tick_en) begin
          if (timer_q <= T_ONE) begin
            st_d    = ST_GREEN;
            timer_d = MIN_D;
            gcnt_d  = '0;
            phase_d = emg_valid ? emg_phase : search_phase;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      ST_GREEN: begin
        if (emg_valid && (emg_phase != phase_q)) begin
          st_d    = ST_YELLOW;
          timer_d = YEL_D;
        end else if (emg_valid) begin
          timer_d = MIN_D;
          gcnt_d  = '0;
        end else if (tick_en) begin
          if (green_done) begin
            st_d    = ST_YELLOW;
            timer_d = YEL_D;
          end else begin
            if (timer_q > T_ONE) begin
              timer_d = timer_q - T_ONE;
            end
            if (gcnt_q != '1) begin
              gcnt_d = gcnt_q + T_ONE;
            end
          end
        end
      end
      ST_YELLOW: begin
        if (tick_en) begin
          if (timer_q <= T_ONE) begin
            st_d    = ST_ALLRED;
            timer_d = AR_D;
          end else begin
            timer_d = timer_q - T_ONE;
          end
        end
      end
      default: begin
        st_d    = ST_ALLRED;
        timer_d = AR_D;
      end
    endcase
    lights_d = lamp_decode(st_d, phase_d);
  end

  // State and registered lamp outputs; reset forces all-red immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= ST_ALLRED;
      timer_q  <= AR_D;
      gcnt_q   <= '0;
      phase_q  <= LAST_PHASE;
      lights_q <= ALL_RED;
    end else begin
      st_q     <= st_d;
      timer_q  <= timer_d;
      gcnt_q   <= gcnt_d;
      phase_q  <= phase_d;
      lights_q <= lights_d;
    end
  end

  assign lights    = lights_q;
  assign cur_phase = phase_q;
  assign state     = st_q;

endmodule

// File: tb/tb_tlc_nway_phase_ctrl.sv
// Testbench for tlc_nway_phase_ctrl: randomized traffic against a tick-counting
// reference model, plus the directed reset/extension/skip scenarios.

module tb_tlc_nway_phase_ctrl;

  localparam int NP  = 4;
  localparam int TW  = 8;
  localparam int MIN = 5;
  localparam int MAX = 10;
  localparam int YT  = 2;
  localparam int AR  = 1;
  localparam int PW  = 2;
  localparam int LW  = 3 * NP;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick_en;
  logic [NP-1:0] veh_req;
  logic          emg_req;
  logic [PW-1:0] emg_phase;
  logic [LW-1:0] lights;
  logic [PW-1:0] cur_phase;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: colour 0 red, 1 green, 2 yellow; elapsed counts ticks
  // spent in the current colour.
  int m_color;
  int m_phase;
  int m_elapsed;

  tlc_nway_phase_ctrl #(
    .NUM_PHASES(NP), .TIMER_W(TW), .MIN_GREEN(MIN), .MAX_GREEN(MAX),
    .YELLOW_TICKS(YT), .ALLRED_TICKS(AR)
  ) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .veh_req(veh_req),
    .emg_req(emg_req), .emg_phase(emg_phase), .lights(lights),
    .cur_phase(cur_phase), .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_color   = 0;
    m_phase   = NP - 1;
    m_elapsed = 0;
  endtask

  function automatic int pick_next(input logic [NP-1:0] r);
    for (int k = 1; k <= NP; k++) begin
      if ((r & (NP'(1) << ((m_phase + k) % NP))) != '0) return (m_phase + k) % NP;
    end
    return (m_phase + 1) % NP;
  endfunction

  task automatic model_step(input bit t, input logic [NP-1:0] r, input bit e, input logic [PW-1:0] ep);
    bit ev;
`ifdef TLC_EMERGENCY_EN
    ev = e && (int'(ep) < NP);
`else
    ev = (e && (int'(ep) < NP)) && 1'b0;
`endif
    if (ev && m_color == 1 && m_phase != int'(ep)) begin
      m_color   = 2;
      m_elapsed = 0;
    end else if (ev && m_color == 1) begin
      m_elapsed = 0;
    end else if (t) begin
      m_elapsed++;
      if (m_color == 0 && m_elapsed >= AR) begin
        m_phase   = ev ? int'(ep) : pick_next(r);
        m_color   = 1;
        m_elapsed = 0;
      end else if (m_color == 1 && m_elapsed >= MIN &&
                   (m_elapsed >= MAX || r != (NP'(1) << m_phase))) begin
        m_color   = 2;
        m_elapsed = 0;
      end else if (m_color == 2 && m_elapsed >= YT) begin
        m_color   = 0;
        m_elapsed = 0;
      end
    end
  endtask

  function automatic logic [LW-1:0] exp_lights();
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < NP; k++) begin
      logic [2:0] g;
      g = 3'b100;
      if (k == m_phase && m_color == 1) g = 3'b001;
      else if (k == m_phase && m_color == 2) g = 3'b010;
      v = v | (LW'(g) << (3 * k));
    end
    return v;
  endfunction

  task automatic check_all();
    checkOutput("lights", 32'(lights), 32'(exp_lights()));
    checkOutput("state", 32'(state), 32'(m_color));
    checkOutput("cur_phase", 32'(cur_phase), 32'(m_phase));
  endtask

  // One clock: drive on the falling edge, step the model at the rising edge,
  // compare just after it.
  task automatic applyStimulus(input bit t, input logic [NP-1:0] r, input bit e, input logic [PW-1:0] ep);
    @(negedge clk);
    tick_en   = t;
    veh_req   = r;
    emg_req   = e;
    emg_phase = ep;
    @(posedge clk);
    if (rst) model_step(t, r, e, ep);
    else model_reset();
    #1;
    check_all();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all();
    @(posedge clk);
    model_step(tick_en, veh_req, emg_req, emg_phase);
    #1;
    check_all();
  endtask

  task automatic wait_for(input int col, input int ph, input logic [NP-1:0] r, input string tag);
    int n;
    n = 0;
    while (!(m_color == col && m_phase == ph) && n < 200) begin
      applyStimulus(1'b1, r, 1'b0, '0);
      n++;
    end
    checkOutput(tag, 32'({state, cur_phase}), 32'({2'(col), PW'(ph)}));
  endtask

  task automatic random_run(input int cycles);
    logic [NP-1:0] r;
    bit            e;
    logic [PW-1:0] ep;
    r  = '0;
    e  = 1'b0;
    ep = '0;
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) r = NP'(1) << $urandom_range(0, NP - 1);
        else r = NP'($urandom);
      end
      if ($urandom_range(0, 99) == 0) begin
        e  = !e;
        ep = PW'($urandom);
      end
      applyStimulus($urandom_range(0, 3) != 0, r, e, ep);
    end
  endtask

  initial begin
    rst       = 1'b0;
    tick_en   = 1'b1;
    veh_req   = '0;
    emg_req   = 1'b0;
    emg_phase = '0;
    model_reset();

    // Reset held for three cycles, then phase 0 takes the first green.
    repeat (3) applyStimulus(1'b1, '0, 1'b0, '0);
    release_reset();
    checkOutput("first_green", 32'(lights), 32'h921);

    // No demand: plain rotation with wrap-around.
    repeat (64) applyStimulus(1'b1, '0, 1'b0, '0);

    // Demand only on phase 3 while phase 0 is green: phases 1 and 2 skipped.
    wait_for(1, 0, '0, "reach_p0_green");
    repeat (12) applyStimulus(1'b1, 4'b1000, 1'b0, '0);
    checkOutput("skip_to_p3", 32'(cur_phase), 32'd3);

    // Sole demand on phase 2 held: green lasts the full cap.
    wait_for(1, 2, '0, "reach_p2_green");
    repeat (9) applyStimulus(1'b1, 4'b0100, 1'b0, '0);
    checkOutput("ext_still_green", 32'(state), 32'd1);
    applyStimulus(1'b1, 4'b0100, 1'b0, '0);
    checkOutput("ext_cap_yellow", 32'(state), 32'd2);

    // Same, but demand drops on tick 7: yellow starts on that tick.
    wait_for(1, 2, 4'b0100, "reach_p2_again");
    repeat (6) applyStimulus(1'b1, 4'b0100, 1'b0, '0);
    checkOutput("drop_still_green", 32'(state), 32'd1);
    applyStimulus(1'b1, 4'b0000, 1'b0, '0);
    checkOutput("drop_yellow", 32'(state), 32'd2);

    random_run(3000);

    // Asynchronous reset in the middle of phase 2 yellow.
    wait_for(2, 2, '0, "reach_p2_yellow");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    checkOutput("async_lights", 32'(lights), 32'h924);
    checkOutput("async_state", 32'(state), 32'd0);
    checkOutput("async_phase", 32'(cur_phase), 32'd3);
    repeat (2) applyStimulus(1'b1, 4'b0010, 1'b0, '0);
    release_reset();

    random_run(800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
